// File: rtl/tree_loader_pkg.sv
// tree_loader_pkg
//   Shared definitions for the decision-tree image loader: FSM state
//   encoding, error codes, record geometry and child-pointer field layout.
//   Optional feature macro used by the loader: LOADER_CHECKSUM_EN.
package tree_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_COLLECT,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_COUNT = 2'd1,
    ERR_CHILD = 2'd2,
    ERR_CSUM  = 2'd3
  } err_t;

  localparam int unsigned REC_BYTES     = 7;
  // The top nibble of every 56-bit record is discarded, so only 52 bits are kept.
  localparam int unsigned REC_USED_BITS = 52;
  localparam int unsigned LEAF_BIT      = 8;
  localparam int unsigned CHILD_W       = 9;
  localparam int unsigned LE_LSB        = 9;
  localparam int unsigned GT_LSB        = 0;

  // A leaf child carries a class label and is always acceptable. A non-leaf
  // child must point forward into the image: never back to the root (0) and
  // never beyond the declared node count.
  function automatic logic child_ok(input logic [CHILD_W-1:0] c, input int unsigned n);
    return c[LEAF_BIT] ||
           ((c[LEAF_BIT-1:0] != '0) && (32'(c[LEAF_BIT-1:0]) < n));
  endfunction

endpackage

// File: rtl/tree_rec_assembler.sv
// tree_rec_assembler
//   Collects big-endian record bytes into a shift register and flags the
//   byte that completes a record.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     i_clear        restarts the byte counter (new load)
//     i_accept       a record byte is being accepted this cycle
//     i_byte         the byte being accepted
//     o_rec          used record bits, valid together with o_rec_valid
//     o_rec_valid    the accepted byte is the last byte of a record
module tree_rec_assembler
  import tree_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_accept,
  input  logic [7:0]               i_byte,
  output logic [REC_USED_BITS-1:0] o_rec,
  output logic                     o_rec_valid
);

  // Only REC_USED_BITS-8 bits are retained, so the ignored top nibble of the
  // first byte falls off the end of the shift register on its own.
  logic [REC_USED_BITS-9:0] r_shift;
  logic [2:0]               r_cnt;
  logic                     w_last;

  assign w_last      = (r_cnt == 3'(REC_BYTES - 1));
  assign o_rec       = {r_shift, i_byte};
  assign o_rec_valid = i_accept && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_accept) begin
      r_shift <= {r_shift[REC_USED_BITS-17:0], i_byte};
      r_cnt   <= w_last ? '0 : r_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/tree_loader.sv
// tree_loader
//   Writer side of the decision-tree node memories. Accepts a byte stream
//   holding a node count N followed by N 7-byte records, validates it, and
//   drives the shared coefficient/child RAM write port. Holds the traversal
//   engine off while a load is running.
//   Optional feature: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     start                 begin a load (ignored while busy)
//     s_valid/s_data/s_ready  byte stream handshake
//     in_addr, ram1_data_in, ram2_data_in, we1   RAM write port
//     eng_hold, busy        load in progress
//     done, err, err_code   sticky completion / abort status
//     nodes_loaded          records written in the current/last load
module tree_loader
  import tree_loader_pkg::*;
#(
  parameter int unsigned RAM1_DATA_WIDTH = 34,
  parameter int unsigned RAM2_DATA_WIDTH = 18,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DEPTH           = 32,
  parameter int unsigned WE_HOLD         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       s_valid,
  input  logic [7:0]                 s_data,
  output logic                       s_ready,
  output logic [ADDR_WIDTH-1:0]      in_addr,
  output logic [RAM1_DATA_WIDTH-1:0] ram1_data_in,
  output logic [RAM2_DATA_WIDTH-1:0] ram2_data_in,
  output logic                       we1,
  output logic                       eng_hold,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [ADDR_WIDTH-1:0]      nodes_loaded
);

  localparam int unsigned HOLD_W = (WE_HOLD > 1) ? $clog2(WE_HOLD) : 1;

  state_t                     r_state, w_next;
  err_t                       r_err_code;
  logic [ADDR_WIDTH-1:0]      r_n, r_nodes, r_addr;
  logic                       r_addr_inc;
  logic [HOLD_W-1:0]          r_hold;
  logic [RAM1_DATA_WIDTH-1:0] r_ram1;
  logic [RAM2_DATA_WIDTH-1:0] r_ram2;
  logic [REC_USED_BITS-1:0]   w_rec;
  logic                       w_rec_valid;
  logic                       w_accept, w_collect, w_start_ok, w_hdr_bad;
  logic                       w_ptr_ok, w_hold_end, w_last_node;

  assign w_accept    = s_valid && s_ready;
  assign w_collect   = w_accept && (r_state == S_COLLECT);
  assign w_start_ok  = start && (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_hdr_bad   = (s_data == 8'd0) || (32'(s_data) > DEPTH);
  assign w_ptr_ok    = child_ok(w_rec[LE_LSB +: CHILD_W], 32'(r_n)) &&
                       child_ok(w_rec[GT_LSB +: CHILD_W], 32'(r_n));
  assign w_hold_end  = (r_hold == HOLD_W'(WE_HOLD - 1));
  assign w_last_node = ((r_nodes + ADDR_WIDTH'(1)) == r_n);

  tree_rec_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_start_ok),
    .i_accept   (w_collect),
    .i_byte     (s_data),
    .o_rec      (w_rec),
    .o_rec_valid(w_rec_valid)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       w_csum_ok;

  assign w_csum_ok = (s_data == r_csum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_csum <= '0;
    else if (w_start_ok)                     r_csum <= '0;
    else if (w_accept && r_state != S_CHECK) r_csum <= r_csum ^ s_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_HDR;
      S_HDR:     if (w_accept) w_next = w_hdr_bad ? S_ERR : S_COLLECT;
      S_COLLECT: if (w_rec_valid) w_next = w_ptr_ok ? S_WRITE : S_ERR;
      S_WRITE: begin
        if (w_hold_end) begin
          if (w_last_node)
`ifdef LOADER_CHECKSUM_EN
            w_next = S_CHECK;
`else
            w_next = S_DONE;
`endif
          else
            w_next = S_COLLECT;
        end
      end
      S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_accept) w_next = w_csum_ok ? S_DONE : S_ERR;
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    we1     = 1'b0;
    busy    = 1'b0;
    unique case (r_state)
      S_HDR, S_COLLECT, S_CHECK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      S_WRITE: begin
        we1  = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // The address advance is deferred one cycle past the end of the write
  // burst so that in_addr stays stable for one cycle after we1 falls; the
  // next record needs at least seven cycles, so nothing else can collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_code <= ERR_NONE;
      r_n        <= '0;
      r_nodes    <= '0;
      r_addr     <= '0;
      r_addr_inc <= 1'b0;
      r_hold     <= '0;
      r_ram1     <= '0;
      r_ram2     <= '0;
    end else begin
      r_hold <= (r_state == S_WRITE) ? r_hold + HOLD_W'(1) : '0;
      if (w_start_ok) begin
        r_err_code <= ERR_NONE;
        r_nodes    <= '0;
        r_addr     <= '0;
        r_addr_inc <= 1'b0;
      end else begin
        if (r_addr_inc) begin
          r_addr     <= r_addr + ADDR_WIDTH'(1);
          r_addr_inc <= 1'b0;
        end
        unique case (r_state)
          S_HDR: begin
            if (w_accept) begin
              if (w_hdr_bad) r_err_code <= ERR_COUNT;
              else begin
                r_n    <= ADDR_WIDTH'(s_data);
                r_addr <= '0;
              end
            end
          end
          S_COLLECT: begin
            if (w_rec_valid) begin
              if (w_ptr_ok) begin
                r_ram1 <= w_rec[RAM2_DATA_WIDTH +: RAM1_DATA_WIDTH];
                r_ram2 <= w_rec[RAM2_DATA_WIDTH-1:0];
              end else begin
                r_err_code <= ERR_CHILD;
              end
            end
          end
          S_WRITE: begin
            if (w_hold_end) begin
              r_nodes    <= r_nodes + ADDR_WIDTH'(1);
              r_addr_inc <= 1'b1;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHECK: if (w_accept && !w_csum_ok) r_err_code <= ERR_CSUM;
`endif
          default: ;
        endcase
      end
    end
  end

  assign eng_hold     = busy;
  assign done         = (r_state == S_DONE);
  assign err          = (r_state == S_ERR);
  assign err_code     = r_err_code;
  assign nodes_loaded = r_nodes;
  assign in_addr      = r_addr;
  assign ram1_data_in = r_ram1;
  assign ram2_data_in = r_ram2;

endmodule
